// File: rtl/reg_file_scoreboard.sv
// 16 x 32-bit register file with per-register pending-write counters for RAW hazard detection.
// Optional write-through bypass from the writeback port: define REGFILE_WB_BYPASS_EN.
module reg_file_scoreboard #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int CNT_W  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADDR_W-1:0]    src1_addr_in,
    input  logic [ADDR_W-1:0]    src2_addr_in,
    input  logic                 src1_valid_in,
    input  logic                 src2_valid_in,
    output logic [DATA_W-1:0]    reg1_out,
    output logic [DATA_W-1:0]    reg2_out,
    input  logic                 issue_en_in,
    input  logic [ADDR_W-1:0]    issue_dest_in,
    input  logic                 wb_en_in,
    input  logic [ADDR_W-1:0]    wb_reg_dest_in,
    input  logic [DATA_W-1:0]    wb_value_in,
    output logic                 hazard_out,
    output logic [2**ADDR_W-1:0] pending_mask_out,
    output logic                 sb_err_out
);
    localparam int NREG = 2**ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0][DATA_W-1:0] regs;
    logic [NREG-1:0][CNT_W-1:0]  cnt;
    logic [NREG-1:0]             err_set;
    logic                        pend1, pend2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           regs <= '0;
        else if (wb_en_in) regs[wb_reg_dest_in] <= wb_value_in;
    end

    for (genvar g = 0; g < NREG; g++) begin : g_sb
        logic             inc, dec;
        logic [CNT_W-1:0] c_q;

        assign inc = issue_en_in && (issue_dest_in == ADDR_W'(g));
        assign dec = wb_en_in && (wb_reg_dest_in == ADDR_W'(g));
        // Simultaneous inc/dec cancel, so they never flag an error even at the limits.
        assign err_set[g] = (inc && !dec && c_q == CNT_MAX) || (dec && !inc && c_q == '0);

        always_ff @(posedge clk or posedge rst) begin
            if (rst) c_q <= '0;
            else if (inc && !dec && c_q != CNT_MAX) c_q <= c_q + 1'b1;
            else if (dec && !inc && c_q != '0)      c_q <= c_q - 1'b1;
        end

        assign cnt[g]              = c_q;
        assign pending_mask_out[g] = (c_q != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)             sb_err_out <= 1'b0;
        else if (|err_set)   sb_err_out <= 1'b1;
    end

`ifdef REGFILE_WB_BYPASS_EN
    logic byp1, byp2;
    assign byp1 = wb_en_in && (wb_reg_dest_in == src1_addr_in);
    assign byp2 = wb_en_in && (wb_reg_dest_in == src2_addr_in);
    assign reg1_out = byp1 ? wb_value_in : regs[src1_addr_in];
    assign reg2_out = byp2 ? wb_value_in : regs[src2_addr_in];
    // The last outstanding write landing this cycle is forwarded, so it no longer stalls.
    assign pend1 = src1_valid_in && (cnt[src1_addr_in] != '0)
                   && !(byp1 && cnt[src1_addr_in] == CNT_W'(1));
    assign pend2 = src2_valid_in && (cnt[src2_addr_in] != '0)
                   && !(byp2 && cnt[src2_addr_in] == CNT_W'(1));
`else
    assign reg1_out = regs[src1_addr_in];
    assign reg2_out = regs[src2_addr_in];
    assign pend1    = src1_valid_in && (cnt[src1_addr_in] != '0);
    assign pend2    = src2_valid_in && (cnt[src2_addr_in] != '0);
`endif

    assign hazard_out = pend1 || pend2;
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Self-checking bench for reg_file_scoreboard; expected values are queued at stimulus time.
module tb_reg_file_scoreboard;
    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  src1_addr_in, src2_addr_in, issue_dest_in, wb_reg_dest_in;
    logic        src1_valid_in, src2_valid_in, issue_en_in, wb_en_in;
    logic [31:0] wb_value_in, reg1_out, reg2_out;
    logic        hazard_out, sb_err_out;
    logic [15:0] pending_mask_out;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    reg_file_scoreboard dut (
        .clk(clk), .rst(rst),
        .src1_addr_in(src1_addr_in), .src2_addr_in(src2_addr_in),
        .src1_valid_in(src1_valid_in), .src2_valid_in(src2_valid_in),
        .reg1_out(reg1_out), .reg2_out(reg2_out),
        .issue_en_in(issue_en_in), .issue_dest_in(issue_dest_in),
        .wb_en_in(wb_en_in), .wb_reg_dest_in(wb_reg_dest_in), .wb_value_in(wb_value_in),
        .hazard_out(hazard_out), .pending_mask_out(pending_mask_out), .sb_err_out(sb_err_out)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_en_in = 1'b0;
        wb_en_in    = 1'b0;
    endtask

    task automatic test_reset();
        src1_addr_in = 4'd15; src2_addr_in = 4'd0;
        src1_valid_in = 1'b1; src2_valid_in = 1'b1;
        exp_q.push_back(32'h0);
        exp_q.push_back(32'h0);
        #1;
        checks++; exp = exp_q.pop_front();
        if (reg1_out !== exp) begin failures++; $display("FAIL reset_reg1 got=%h exp=%h", reg1_out, exp); end
        checks++; exp = exp_q.pop_front();
        if (reg2_out !== exp) begin failures++; $display("FAIL reset_reg2 got=%h exp=%h", reg2_out, exp); end
        checks++;
        if (pending_mask_out !== 16'h0) begin failures++; $display("FAIL reset_mask got=%h exp=0", pending_mask_out); end
        checks++;
        if (hazard_out !== 1'b0) begin failures++; $display("FAIL reset_hazard got=%b exp=0", hazard_out); end
        checks++;
        if (sb_err_out !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", sb_err_out); end
    endtask

    task automatic test_write_read();
        issue_en_in = 1'b1; issue_dest_in = 4'd3;
        tick();
        issue_en_in = 1'b0;
        wb_en_in = 1'b1; wb_reg_dest_in = 4'd3; wb_value_in = 32'hDEADBEEF;
        src1_addr_in = 4'd3; src1_valid_in = 1'b0; src2_valid_in = 1'b0;
        exp_q.push_back(BYP ? 32'hDEADBEEF : 32'h0);
        #1;
        checks++; exp = exp_q.pop_front();
        if (reg1_out !== exp) begin failures++; $display("FAIL wr_same_cycle got=%h exp=%h", reg1_out, exp); end
        tick();
        idle();
        exp_q.push_back(32'hDEADBEEF);
        exp_q.push_back(32'h0);
        #1;
        checks++; exp = exp_q.pop_front();
        if (reg1_out !== exp) begin failures++; $display("FAIL wr_next_cycle got=%h exp=%h", reg1_out, exp); end
        checks++; exp = exp_q.pop_front();
        if ({16'h0, pending_mask_out} !== exp) begin failures++; $display("FAIL wr_mask got=%h exp=%h", pending_mask_out, exp); end
        checks++;
        if (sb_err_out !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", sb_err_out); end
    endtask

    task automatic test_hazard();
        issue_en_in = 1'b1; issue_dest_in = 4'd5;
        tick();
        issue_en_in = 1'b0;
        src2_addr_in = 4'd5; src2_valid_in = 1'b1;
        src1_addr_in = 4'd0; src1_valid_in = 1'b1;
        exp_q.push_back(32'h0000_0020);
        #1;
        checks++;
        if (hazard_out !== 1'b1) begin failures++; $display("FAIL hz_valid got=%b exp=1", hazard_out); end
        checks++; exp = exp_q.pop_front();
        if ({16'h0, pending_mask_out} !== exp) begin failures++; $display("FAIL hz_mask got=%h exp=%h", pending_mask_out, exp); end
        src2_valid_in = 1'b0;
        #1;
        checks++;
        if (hazard_out !== 1'b0) begin failures++; $display("FAIL hz_invalid got=%b exp=0", hazard_out); end
        src2_valid_in = 1'b1;
        wb_en_in = 1'b1; wb_reg_dest_in = 4'd5; wb_value_in = 32'h1234;
        exp_q.push_back(BYP ? 32'h1234 : 32'h0);
        #1;
        checks++;
        if (hazard_out !== !BYP) begin failures++; $display("FAIL hz_wb_cycle got=%b exp=%b", hazard_out, !BYP); end
        checks++; exp = exp_q.pop_front();
        if (reg2_out !== exp) begin failures++; $display("FAIL hz_wb_data got=%h exp=%h", reg2_out, exp); end
        tick();
        idle();
        exp_q.push_back(32'h1234);
        #1;
        checks++;
        if (hazard_out !== 1'b0) begin failures++; $display("FAIL hz_after_wb got=%b exp=0", hazard_out); end
        checks++; exp = exp_q.pop_front();
        if (reg2_out !== exp) begin failures++; $display("FAIL hz_after_data got=%h exp=%h", reg2_out, exp); end
        src1_valid_in = 1'b0; src2_valid_in = 1'b0;
    endtask

    task automatic test_simultaneous();
        // count 0: cancel, and a same-cycle read of R9 sees the pre-edge count
        issue_en_in = 1'b1; issue_dest_in = 4'd9;
        wb_en_in = 1'b1; wb_reg_dest_in = 4'd9; wb_value_in = 32'h99;
        src1_addr_in = 4'd9; src1_valid_in = 1'b1;
        #1;
        checks++;
        if (hazard_out !== 1'b0) begin failures++; $display("FAIL sim_read_pre got=%b exp=0", hazard_out); end
        tick();
        idle();
        src1_valid_in = 1'b0;
        exp_q.push_back(32'h0);
        #1;
        checks++; exp = exp_q.pop_front();
        if ({16'h0, pending_mask_out} !== exp) begin failures++; $display("FAIL sim_cnt0_mask got=%h exp=%h", pending_mask_out, exp); end
        checks++;
        if (sb_err_out !== 1'b0) begin failures++; $display("FAIL sim_cnt0_err got=%b exp=0", sb_err_out); end
        issue_en_in = 1'b1; issue_dest_in = 4'd9;
        tick();
        wb_en_in = 1'b1; wb_reg_dest_in = 4'd9; wb_value_in = 32'h9A;
        tick();
        idle();
        exp_q.push_back(32'h0000_0200);
        #1;
        checks++; exp = exp_q.pop_front();
        if ({16'h0, pending_mask_out} !== exp) begin failures++; $display("FAIL sim_cnt1_mask got=%h exp=%h", pending_mask_out, exp); end
        checks++;
        if (sb_err_out !== 1'b0) begin failures++; $display("FAIL sim_cnt1_err got=%b exp=0", sb_err_out); end
        wb_en_in = 1'b1; wb_reg_dest_in = 4'd9; wb_value_in = 32'h9B;
        tick();
        idle();
        exp_q.push_back(32'h0);
        #1;
        checks++; exp = exp_q.pop_front();
        if ({16'h0, pending_mask_out} !== exp) begin failures++; $display("FAIL sim_drain_mask got=%h exp=%h", pending_mask_out, exp); end
    endtask

    task automatic test_saturation();
        issue_en_in = 1'b1; issue_dest_in = 4'd7;
        for (int i = 0; i < 3; i++) tick();
        issue_en_in = 1'b0;
        #1;
        checks++;
        if (pending_mask_out !== 16'h0080 || sb_err_out !== 1'b0) begin
            failures++; $display("FAIL sat_three got=%h/%b exp=0080/0", pending_mask_out, sb_err_out);
        end
        issue_en_in = 1'b1;
        tick();
        idle();
        #1;
        checks++;
        if (sb_err_out !== 1'b1) begin failures++; $display("FAIL sat_overflow_err got=%b exp=1", sb_err_out); end
        wb_en_in = 1'b1; wb_reg_dest_in = 4'd7; wb_value_in = 32'h77;
        tick(); tick();
        #1;
        checks++;
        if (pending_mask_out !== 16'h0080) begin failures++; $display("FAIL sat_held_at_max got=%h exp=0080", pending_mask_out); end
        tick();
        idle();
        #1;
        checks++;
        if (pending_mask_out !== 16'h0000) begin failures++; $display("FAIL sat_drained got=%h exp=0000", pending_mask_out); end
        checks++;
        if (sb_err_out !== 1'b1) begin failures++; $display("FAIL sat_err_sticky got=%b exp=1", sb_err_out); end
    endtask

    task automatic test_reset_mid();
        issue_en_in = 1'b1; issue_dest_in = 4'd4;
        tick(); tick();
        issue_en_in = 1'b0;
        wb_en_in = 1'b1; wb_reg_dest_in = 4'd4; wb_value_in = 32'hCAFE_F00D;
        tick();
        idle();
        src1_addr_in = 4'd4; src1_valid_in = 1'b1;
        #1;
        checks++;
        if (pending_mask_out !== 16'h0010 || hazard_out !== 1'b1 || reg1_out !== 32'hCAFE_F00D) begin
            failures++; $display("FAIL rstmid_pre got=%h/%b/%h exp=0010/1/cafef00d", pending_mask_out, hazard_out, reg1_out);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (pending_mask_out !== 16'h0 || hazard_out !== 1'b0 || sb_err_out !== 1'b0) begin
            failures++; $display("FAIL rstmid_flags got=%h/%b/%b exp=0/0/0", pending_mask_out, hazard_out, sb_err_out);
        end
        checks++;
        if (reg1_out !== 32'h0) begin failures++; $display("FAIL rstmid_reg got=%h exp=0", reg1_out); end
        tick();
        rst = 1'b0;
        src1_valid_in = 1'b0;
    endtask

    task automatic test_underflow();
        wb_en_in = 1'b1; wb_reg_dest_in = 4'd2; wb_value_in = 32'h0000_A5A5;
        src1_addr_in = 4'd2;
        exp_q.push_back(32'h0000_A5A5);
        tick();
        idle();
        #1;
        checks++; exp = exp_q.pop_front();
        if (reg1_out !== exp) begin failures++; $display("FAIL uf_data got=%h exp=%h", reg1_out, exp); end
        checks++;
        if (pending_mask_out !== 16'h0) begin failures++; $display("FAIL uf_mask got=%h exp=0", pending_mask_out); end
        checks++;
        if (sb_err_out !== 1'b1) begin failures++; $display("FAIL uf_err got=%b exp=1", sb_err_out); end
    endtask

    initial begin
        rst = 1'b1;
        src1_addr_in = '0; src2_addr_in = '0; src1_valid_in = 1'b0; src2_valid_in = 1'b0;
        issue_en_in = 1'b0; issue_dest_in = '0;
        wb_en_in = 1'b0; wb_reg_dest_in = '0; wb_value_in = '0;
        #12;
        test_reset();
        rst = 1'b0;
        tick();
        test_write_read();
        test_hazard();
        test_simultaneous();
        test_saturation();
        test_reset_mid();
        test_underflow();
        if (exp_q.size() != 0) begin
            checks++; failures++;
            $display("FAIL queue_leftover got=%0d exp=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
